// File: rtl/pll_dri_master.sv
// pll_dri_master: initiator for the PolarFire PLL Dynamic Reconfiguration Interface.
// Turns single-beat register read/write commands into a DRI_CTRL/DRI_WDATA request
// and returns DRI_RDATA[31:0] to the requester. Each request either receives an ack
// or times out. DRI_INTERRUPT is captured into a sticky flag.
//
// Ports:
//   DRI_CLK, DRI_ARST_N             clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata command channel (valid/ready)
//   rsp_valid/ready/rdata/err       response channel (valid/ready)
//   DRI_CTRL [10]=req [9]=wr [8:0]=addr, DRI_WDATA [32]=0 [31:0]=data
//   DRI_RDATA [32]=ack [31:0]=data, DRI_INTERRUPT level interrupt from the PLL
//   irq_pending / irq_clr           sticky interrupt flag and its clear
module pll_dri_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        DRI_CLK,
  input  logic        DRI_ARST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [8:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [10:0] DRI_CTRL,
  output logic [32:0] DRI_WDATA,
  input  logic [32:0] DRI_RDATA,
  input  logic        DRI_INTERRUPT,
  output logic        irq_pending,
  input  logic        irq_clr
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);

  state_e      r_state;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [10:0] r_ctrl;
  logic [32:0] r_wdata;
  logic [15:0] r_cnt;
  logic        r_irq;

  logic [15:0] w_cnt_inc;
  logic        w_timeout;

  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  // Evaluated against the value the counter takes at this edge, so the request
  // gets exactly TIMEOUT_CYCLES cycles in WAIT to be acked.
  assign w_timeout = (w_cnt_inc >= TimeoutLim);

  always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
    if (!DRI_ARST_N) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_ctrl      <= 11'd0;
      r_wdata     <= 33'd0;
      r_cnt       <= 16'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Accept only on the registered ready, so the first edge after reset
          // merely raises cmd_ready.
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_ctrl      <= {1'b1, cmd_write, cmd_addr};
            r_wdata     <= cmd_write ? {1'b0, cmd_wdata} : 33'd0;
            r_state     <= StIssue;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        StIssue: begin
          // Request strobe lasts a single cycle; write/addr/data stay held.
          r_ctrl[10] <= 1'b0;
          r_cnt      <= 16'd0;
          r_state    <= StWait;
        end
        StWait: begin
          r_cnt <= w_cnt_inc;
          // Ack takes priority over a timeout in the same cycle.
          if (DRI_RDATA[32]) begin
            r_rsp_rdata <= r_ctrl[9] ? 32'd0 : DRI_RDATA[31:0];
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else if (w_timeout) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_ctrl      <= 11'd0;
            r_wdata     <= 33'd0;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Sticky interrupt capture; a set in the same cycle as a clear wins.
  always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
    if (!DRI_ARST_N) begin
      r_irq <= 1'b0;
    end else if (DRI_INTERRUPT) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign DRI_CTRL    = r_ctrl;
  assign DRI_WDATA   = r_wdata;
  assign irq_pending = r_irq;

endmodule

// File: doc/pll_dri_master.md
Name: pll_dri_master

Overview:
- Initiator for the PolarFire PLL Dynamic Reconfiguration Interface (DRI).
- Converts single-beat register read/write commands from fabric logic into DRI_CTRL/DRI_WDATA transactions, and returns DRI_RDATA to the requester.
- Includes a response timeout and a sticky capture of DRI_INTERRUPT.
- Sits between the clock-management controller and the PLL instance's DRI ports, which are currently tied off.

Parameters:
TIMEOUT_CYCLES, 255, max DRI_CLK cycles spent in WAIT before aborting with error; legal range 1..65535

Ports:
DRI_CLK  in  1  DRI clock; all logic on rising edge
DRI_ARST_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  9  DRI register address
cmd_wdata  in  32  write data
rsp_valid  out  1  response available
rsp_ready  in  1  requester consumes response
rsp_rdata  out  32  read data; 0 for writes and errors
rsp_err  out  1  1 = transaction timed out
DRI_CTRL  out  11  [10]=req strobe, [9]=write, [8:0]=addr
DRI_WDATA  out  33  [32]=0, [31:0]=write data
DRI_RDATA  in  33  [32]=ack from target, [31:0]=read data
DRI_INTERRUPT  in  1  target interrupt, level
irq_pending  out  1  sticky DRI_INTERRUPT capture
irq_clr  in  1  clears irq_pending

Behaviour:
- Reset (DRI_ARST_N=0, async):
  - FSM goes to IDLE.
  - cmd_ready=0 while in reset, 1 from the first clock after deassertion.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, DRI_CTRL=0, DRI_WDATA=0, irq_pending=0, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge N, latch write/addr/wdata, go to ISSUE, drop cmd_ready.
- ISSUE (cycle N+1):
  - DRI_CTRL={1,write,addr} for exactly one cycle.
  - DRI_WDATA={0,wdata} for writes, 0 for reads.
  - Next state is WAIT; counter is cleared.
- WAIT:
  - DRI_CTRL[10]=0. DRI_CTRL[9:0] and DRI_WDATA stay held until RESP exit.
  - Counter increments each cycle.
  - On DRI_RDATA[32]=1: capture DRI_RDATA[31:0] (reads) or 0 (writes), set rsp_err=0, go to RESP.
  - If counter reaches TIMEOUT_CYCLES with no ack: rsp_rdata=0, rsp_err=1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
  - DRI_RDATA[32] is ignored in IDLE, ISSUE and RESP. Stray acks have no effect.
- RESP:
  - rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_valid&rsp_ready.
  - On handshake go to IDLE. rsp_valid drops and cmd_ready rises on the next cycle.
  - Earliest back-to-back accept is the cycle after that.
- Minimum latency: accept at edge N, req at N+1, ack at N+2 → rsp_valid at N+3.
- cmd_valid is ignored while cmd_ready=0. The command must be held by the requester.
- irq_pending:
  - Set on any cycle with DRI_INTERRUPT=1. Cleared by irq_clr.
  - Set wins over clear in the same cycle.
  - Independent of the FSM.
- Reset asserted mid-transaction:
  - Aborts immediately: all outputs go to reset values and no response is produced.
  - After reset the target may still ack; WAIT is not active, so the ack is dropped.
- Timeout counter width is 16 bits and saturates. It never wraps.

Test Plan:
- Read: cmd addr=0x012 write=0; target acks 2 cycles after req with data 0x0000_ABCD → DRI_CTRL=0x412 for 1 cycle; rsp_valid with rdata=0xABCD, err=0.
- Write: addr=0x1FF wdata=0xDEADBEEF; ack after 1 cycle → DRI_CTRL=0x7FF, DRI_WDATA=0x0DEADBEEF; rsp rdata=0, err=0.
- Timeout: TIMEOUT_CYCLES=8, no ack → rsp_valid 8 cycles after entering WAIT, err=1, rdata=0. A late ack afterwards is ignored, and the next command completes normally.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp stays stable, cmd_ready=0, and a new cmd_valid is not accepted until after the handshake.
- Interrupt: pulse DRI_INTERRUPT 1 cycle → irq_pending=1 until irq_clr. With irq_clr and DRI_INTERRUPT both asserted in the same cycle → irq_pending stays 1.
- Reset mid-WAIT: assert DRI_ARST_N low during WAIT → outputs go to 0 asynchronously. After release, cmd_ready=1 and no rsp_valid appears; the next read returns correct data.
